// File: rtl/mkio_bus_controller.sv
// MKIO bus-controller end: sends a command word, optional data words from a
// local 32x16 buffer, collects the RT status word and optional data words.
//
// state        | meaning
// S_IDLE       | waiting for start
// S_SEND_CMD   | transmitting the command word (tx_cd=0)
// S_SEND_DATA  | transmitting buffer[0..N-1] (tx_cd=1)
// S_WAIT_STATUS| waiting for the RT status word, timeout armed
// S_RECV_DATA  | storing N received data words into the buffer
// S_DONE       | one-cycle completion, err/status_word valid
module mkio_bus_controller #(
  parameter int TIMEOUT_CYCLES = 700
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  rt_addr,
  input  logic        tr,
  input  logic [4:0]  subaddr,
  input  logic [4:0]  word_count,
  input  logic        buf_we,
  input  logic [4:0]  buf_addr,
  input  logic [15:0] buf_wdata,
  output logic [15:0] buf_rdata,
  output logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  input  logic        rx_cd,
  input  logic        p_error,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic [15:0] status_word
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CMD, S_SEND_DATA, S_WAIT_STATUS, S_RECV_DATA, S_DONE
  } state_t;

  // Per-word transmit handshake: PREP gives the buffer read one cycle to land.
  localparam logic [1:0] PH_PREP    = 2'd0;
  localparam logic [1:0] PH_ISSUE   = 2'd1;
  localparam logic [1:0] PH_WAIT_HI = 2'd2;
  localparam logic [1:0] PH_WAIT_LO = 2'd3;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_PARITY  = 3'd2;
  localparam logic [2:0] ERR_ADDR    = 3'd3;
  localparam logic [2:0] ERR_SYNC    = 3'd4;
  localparam logic [2:0] ERR_MSG     = 3'd5;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_tx_ph;
  logic [TW-1:0] r_tmr;
  logic [4:0]  r_idx;
  logic [4:0]  r_rt_addr;
  logic [4:0]  r_sa;
  logic [4:0]  r_wc;
  logic        r_tr;
  logic        r_tx_ready;
  logic [15:0] r_tx_data;
  logic        r_tx_cd;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_err;
  logic [15:0] r_status;
  logic [15:0] r_mem [32];
  logic [15:0] r_rd_word;
  logic [15:0] r_buf_rdata;

  logic        w_last;
  logic [15:0] w_cmd_word;
  logic        w_rx_wr;
  logic        w_host_wr;

  // word_count 0 means 32; the 5-bit wrap of r_wc-1 gives index 31 for it.
  assign w_last     = (r_idx == r_wc - 5'd1);
  assign w_cmd_word = {r_rt_addr, r_tr, r_sa, r_wc};
  assign w_rx_wr    = (r_state == S_RECV_DATA) && rx_done && rx_cd && !p_error;
  assign w_host_wr  = buf_we && !r_busy;

  // Buffer: one write port (receive path or host), host and transmit read ports.
  always_ff @(posedge clk) begin
    if (w_rx_wr)
      r_mem[r_idx] <= rx_data;
    else if (w_host_wr)
      r_mem[buf_addr] <= buf_wdata;
    r_buf_rdata <= r_mem[buf_addr];
    r_rd_word   <= r_mem[r_idx];
  end

  // Transaction sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tx_ph    <= PH_PREP;
      r_tmr      <= '0;
      r_idx      <= '0;
      r_rt_addr  <= '0;
      r_sa       <= '0;
      r_wc       <= '0;
      r_tr       <= 1'b0;
      r_tx_ready <= 1'b0;
      r_tx_data  <= '0;
      r_tx_cd    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= ERR_OK;
      r_status   <= '0;
    end else begin
      r_tx_ready <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && !r_busy) begin
            r_rt_addr <= rt_addr;
            r_tr      <= tr;
            r_sa      <= subaddr;
            r_wc      <= word_count;
            r_err     <= ERR_OK;
            r_busy    <= 1'b1;
            r_tx_ph   <= PH_PREP;
            r_idx     <= '0;
            r_state   <= S_SEND_CMD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SEND_CMD, S_SEND_DATA: begin
          case (r_tx_ph)
            PH_PREP: r_tx_ph <= PH_ISSUE;
            PH_ISSUE: begin
              if (!tx_busy) begin
                r_tx_ready <= 1'b1;
                r_tx_data  <= (r_state == S_SEND_CMD) ? w_cmd_word : r_rd_word;
                r_tx_cd    <= (r_state == S_SEND_DATA);
                r_tx_ph    <= PH_WAIT_HI;
              end
            end
            PH_WAIT_HI: if (tx_busy) r_tx_ph <= PH_WAIT_LO;
            default: begin
              if (!tx_busy) begin
                r_tx_ph <= PH_PREP;
                if (r_state == S_SEND_CMD) begin
                  r_idx   <= '0;
                  r_tmr   <= TMR_LOAD;
                  r_state <= r_tr ? S_WAIT_STATUS : S_SEND_DATA;
                end else if (w_last) begin
                  r_tmr   <= TMR_LOAD;
                  r_state <= S_WAIT_STATUS;
                end else begin
                  r_idx <= r_idx + 5'd1;
                end
              end
            end
          endcase
        end
        S_WAIT_STATUS: begin
          if (rx_done) begin
            if (p_error || rx_cd) begin
              r_err   <= p_error ? ERR_PARITY : ERR_SYNC;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_status <= rx_data;
              if (rx_data[15:11] != r_rt_addr || rx_data[10] || !r_tr) begin
                r_err   <= (rx_data[15:11] != r_rt_addr) ? ERR_ADDR :
                           (rx_data[10] ? ERR_MSG : ERR_OK);
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_idx   <= '0;
                r_tmr   <= TMR_LOAD;
                r_state <= S_RECV_DATA;
              end
            end
          end else if (r_tmr == '0) begin
            r_err   <= ERR_TIMEOUT;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end
        S_RECV_DATA: begin
          if (rx_done) begin
            if (p_error || !rx_cd || w_last) begin
              r_err   <= p_error ? ERR_PARITY : (!rx_cd ? ERR_SYNC : ERR_OK);
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 5'd1;
              r_tmr <= TMR_LOAD;
            end
          end else if (r_tmr == '0) begin
            r_err   <= ERR_TIMEOUT;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign buf_rdata   = r_buf_rdata;
  assign tx_ready    = r_tx_ready;
  assign tx_data     = r_tx_data;
  assign tx_cd       = r_tx_cd;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign status_word = r_status;

endmodule

// File: doc/mkio_bus_controller.md
Name: mkio_bus_controller

Overview:
- Bus-controller (initiator) end of the MKIO link; drives the same word-level transmitter/receiver interface the remote-terminal side uses.
- On a start pulse it sends one command word. For BC->RT it then sends N data words from a local 32x16 buffer. It receives the RT status word, and for RT->BC it stores N received data words into that buffer.
- Reports completion, the captured status word and an error code to host logic.

Parameters:
- TIMEOUT_CYCLES, 700, clk cycles allowed from end of last sent word to status rx_done, and between received data words (14 us at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only when busy=0
- rt_addr  in  5  target RT address
- tr  in  1  1 = RT transmits (RT->BC), 0 = RT receives (BC->RT)
- subaddr  in  5  target subaddress
- word_count  in  5  data words; 0 encodes 32
- buf_we  in  1  host buffer write strobe; ignored while busy=1
- buf_addr  in  5  host buffer address
- buf_wdata  in  16  host write data
- buf_rdata  out  16  buffer read data, registered, 1-cycle latency, readable any time
- tx_ready  out  1  one-cycle pulse, word valid on tx_data/tx_cd
- tx_data  out  16  word to transmitter
- tx_cd  out  1  0 = command/status sync, 1 = data sync
- tx_busy  in  1  transmitter busy
- rx_done  in  1  one-cycle pulse, received word valid
- rx_data  in  16  received word
- rx_cd  in  1  0 = command/status sync, 1 = data sync
- p_error  in  1  parity error on the current rx_done word
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction (success or error)
- err  out  3  result: 0 ok, 1 timeout, 2 parity, 3 status address mismatch, 4 wrong sync type, 5 status message-error bit set
- status_word  out  16  last received status word

Behaviour:
- Reset values: tx_ready=0, tx_data=0, tx_cd=0, busy=0, done=0, err=0, status_word=0, state=IDLE. Buffer contents are not cleared.
- Command word = {rt_addr, tr, subaddr, word_count}. rt_addr, tr, subaddr and N are latched at start; N = 32 when word_count=0.
- Transmit handshake:
  - tx_ready pulses one cycle, only in a cycle where tx_busy=0.
  - FSM then waits for tx_busy=1, then for tx_busy=0; that falling edge marks the word as sent.
  - At most one word is outstanding.
- FSM states:
  - IDLE: start & ~busy -> SEND_CMD; busy=1 from the next cycle.
  - SEND_CMD: sends the command with tx_cd=0. When sent: tr=0 -> SEND_DATA; tr=1 -> WAIT_STATUS.
  - SEND_DATA: sends buffer[0..N-1] in order, tx_cd=1. Buffer read is pipelined so each word is presented with tx_ready. After word N-1 is sent -> WAIT_STATUS.
  - WAIT_STATUS:
    - Timeout counter is cleared on entry; expiry after TIMEOUT_CYCLES cycles -> err=1.
    - On rx_done: p_error -> err=2; rx_cd=1 -> err=4. Otherwise status_word captures rx_data, then rx_data[15:11]!=rt_addr -> err=3; rx_data[10]=1 -> err=5.
    - Any error -> DONE. Clean status: tr=0 -> DONE (err=0); tr=1 -> RECV_DATA.
  - RECV_DATA:
    - Word i is written to buffer[i] on rx_done with rx_cd=1 and no p_error.
    - Timeout counter restarts after each word.
    - rx_cd=0 -> err=4; p_error -> err=2; timeout -> err=1.
    - After N words -> DONE.
  - DONE: done=1 for one cycle, err valid and held until the next start, busy=0 -> IDLE.
- err clears to 0 on an accepted start.
- rx_done pulses arriving in IDLE, SEND_CMD or SEND_DATA are ignored.
- start while busy=1 is ignored; it is not queued.
- rx_done and timeout expiry in the same cycle: rx_done wins.
- Reset mid-transaction: immediate return to IDLE, tx_ready deasserted, no done pulse.
- Host buffer write and internal RECV_DATA write cannot collide, because host writes are gated by busy.

Test Plan:
- BC->RT: buffer[0..2]=0x1111,0x2222,0x3333; start rt_addr=1, tr=0, subaddr=3, wc=3 -> tx words 0x0863(cd0), 0x1111, 0x2222, 0x3333(cd1). RT replies status 0x0800 (cd0) -> done, err=0, status_word=0x0800.
- RT->BC: start rt_addr=1, tr=1, subaddr=5, wc=2 -> tx 0x0CA2. Rx status 0x0800, then data 0xABCD, 0x1234 (cd1) -> done, err=0; buf_rdata at addr 0/1 = 0xABCD/0x1234.
- Timeout: BC->RT with wc=1 and no RT reply -> done exactly TIMEOUT_CYCLES (+ fixed latency) after tx_busy falls, err=1.
- Errors: status 0x1000 for rt_addr=1 -> err=3. Status with p_error=1 -> err=2. Status 0x0C00 (bit 10 set) -> err=5. Data word with rx_cd=0 during RECV_DATA -> err=4.
- wc=0 with tr=0 -> exactly 32 data words sent from buffer[0..31] before WAIT_STATUS.
- Holding tx_busy=1 delays tx_ready until tx_busy=0. A start pulse mid-transfer is ignored. reset during SEND_DATA -> busy=0, tx_ready=0, no done pulse; a new start then works normally.
